// File: rtl/cmp_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package cmp_pkg;

  localparam int NIBBLE_W = 4;

  // Cascade seed: "no greater-than yet, still equal so far".
  localparam logic FLAG_L_RST = 1'b0;
  localparam logic FLAG_G_RST = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/comparator_4b.sv
// 4-bit cascadable magnitude comparator stage (l: A>B, g: A==B, m: A<B).
module comparator_4b
  import cmp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                in_l,
  input  logic                in_g,
  input  logic                in_m,
  output logic                l,
  output logic                g,
  output logic                m
);

  // A decision made by a more significant stage wins; this nibble only matters while equal.
  always_comb begin
    l = in_l | (in_g & (a > b));
    g = in_g & (a == b);
    m = in_m | (in_g & (a < b));
  end

endmodule

// File: rtl/comparator_serial.sv
// Nibble-serial magnitude comparator, MSB nibble first, valid/ready in and out.
// Build option: COMPARATOR_SERIAL_SIGNED_EN treats operands as two's complement.
module comparator_serial
  import cmp_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int CNT_W   = $clog2(NIBBLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NIBBLE_W-1:0] in_a,
  input  logic [NIBBLE_W-1:0] in_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                res_l,
  output logic                res_g,
  output logic                res_m,
  output logic                busy
);

  if (NIBBLES < 2 || NIBBLES > 16) begin : g_bad_nibbles
    $error("comparator_serial: NIBBLES must be in 2..16");
  end

  state_t               state;
  state_t               next_state;
  logic [CNT_W-1:0]     cnt;
  logic                 acc_l;
  logic                 acc_g;
  logic                 accept;
  logic                 last_beat;
  logic                 first_beat;
  logic [NIBBLE_W-1:0]  stage_a;
  logic [NIBBLE_W-1:0]  stage_b;
  logic                 stage_in_l;
  logic                 stage_in_g;
  logic                 stage_in_m;
  logic                 stage_l;
  logic                 stage_g;
  logic                 stage_m;

  assign first_beat = (state == IDLE);
  assign accept     = in_valid & in_ready;
  assign last_beat  = (state == ACCUM) && (cnt == CNT_W'(NIBBLES - 1));
  assign res_valid  = (state == HOLD);

  // The MSB nibble starts from the fixed cascade seed rather than stale accumulators.
  always_comb begin
    stage_a    = in_a;
    stage_b    = in_b;
    stage_in_l = first_beat ? FLAG_L_RST : acc_l;
    stage_in_g = first_beat ? FLAG_G_RST : acc_g;
    stage_in_m = ~(stage_in_l | stage_in_g);
`ifdef COMPARATOR_SERIAL_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order.
    if (first_beat) begin
      stage_a[NIBBLE_W-1] = ~in_a[NIBBLE_W-1];
      stage_b[NIBBLE_W-1] = ~in_b[NIBBLE_W-1];
    end
`endif
  end

  comparator_4b u_stage (
    .a    (stage_a),
    .b    (stage_b),
    .in_l (stage_in_l),
    .in_g (stage_in_g),
    .in_m (stage_in_m),
    .l    (stage_l),
    .g    (stage_g),
    .m    (stage_m)
  );

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) next_state = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && last_beat) next_state = HOLD;
      end
      HOLD: begin
        if (res_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Result flags are captured on the final beat so they stay stable through HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      acc_l <= FLAG_L_RST;
      acc_g <= FLAG_G_RST;
      res_l <= 1'b0;
      res_g <= 1'b0;
      res_m <= 1'b0;
    end else begin
      if (accept) begin
        acc_l <= stage_l;
        acc_g <= stage_g;
        cnt   <= first_beat ? CNT_W'(1) : cnt + CNT_W'(1);
      end
      if (accept && last_beat) begin
        res_l <= stage_l;
        res_g <= stage_g;
        res_m <= stage_m;
      end
      if (state == HOLD && res_ready) begin
        cnt   <= '0;
        acc_l <= FLAG_L_RST;
        acc_g <= FLAG_G_RST;
      end
    end
  end

endmodule

// File: tb/tb_comparator_serial.sv
// Directed scoreboard bench for comparator_serial with NIBBLES=4 (16-bit operands).
module tb_comparator_serial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       res_valid;
  logic       res_ready;
  logic       res_l;
  logic       res_g;
  logic       res_m;
  logic       busy;

  int checks;
  int failures;
  logic [2:0] sb[$];

  comparator_serial #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_l     (res_l),
    .res_g     (res_g),
    .res_m     (res_m),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference model: expected {l, g, m}.
  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef COMPARATOR_SERIAL_SIGNED_EN
    return {$signed(a) > $signed(b), a == b, $signed(a) < $signed(b)};
`else
    return {a > b, a == b, a < b};
`endif
  endfunction

  // Called at a negedge; drives one beat and returns at the next negedge.
  task automatic send_beat(input logic [3:0] a_n, input logic [3:0] b_n);
    in_valid = 1'b1;
    in_a     = a_n;
    in_b     = b_n;
    check("in_ready_beat", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // g1..g3 are idle cycles inserted before beats 1..3.
  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b,
                                input int g1, input int g2, input int g3);
    int gaps[4];
    gaps = '{0, g1, g2, g3};
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) begin
        in_valid = 1'b0;
        in_a     = $urandom_range(0, 15);
        in_b     = $urandom_range(0, 15);
        check("busy_gap", busy, 1'b1);
        @(negedge clk);
      end
      send_beat(a[15-4*i -: 4], b[15-4*i -: 4]);
    end
    sb.push_back(model(a, b));
  endtask

  // Called right after the last beat; result must already be valid.
  task automatic check_output(input string tag, input int hold_cycles);
    logic [2:0] exp_flags;
    check({tag, "_latency"}, res_valid, 1'b1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    exp_flags = (sb.size() > 0) ? sb.pop_front() : 3'b000;
    check({tag, "_flags"}, {res_l, res_g, res_m}, exp_flags);
    check({tag, "_onehot"}, res_l + res_g + res_m, 16'd1);
    if (hold_cycles > 0) begin
      in_valid = 1'b1;
      in_a     = 4'hF;
      in_b     = 4'h0;
      repeat (hold_cycles) begin
        @(negedge clk);
        check({tag, "_hold_in_ready"}, in_ready, 1'b0);
        check({tag, "_hold_valid"}, res_valid, 1'b1);
        check({tag, "_hold_flags"}, {res_l, res_g, res_m}, exp_flags);
      end
      in_valid = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_consumed"}, res_valid, 1'b0);
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'h0;
    in_b      = 4'h0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_flags", {res_l, res_g, res_m}, 3'b000);

    $display("[TB] equal operands, back-to-back beats");
    apply_stimulus(16'h1234, 16'h1234, 0, 0, 0);
    check_output("eq", 0);

    $display("[TB] decided on first nibble");
    apply_stimulus(16'hA000, 16'h9FFF, 0, 0, 0);
    check_output("msb_decide", 0);

    $display("[TB] gaps in in_valid");
    apply_stimulus(16'h00F0, 16'h0100, 2, 0, 1);
    check_output("gaps", 0);

    $display("[TB] downstream stall in HOLD");
    apply_stimulus(16'h5A5A, 16'h5A59, 0, 1, 0);
    check_output("stall", 5);

    $display("[TB] reset in the middle of a compare");
    send_beat(4'hF, 4'h0);
    send_beat(4'hF, 4'h0);
    check("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", res_valid, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    apply_stimulus(16'h0001, 16'h0000, 0, 0, 0);
    check_output("after_rst_gt", 0);
    apply_stimulus(16'h0000, 16'h0001, 0, 0, 0);
    check_output("after_rst_lt", 0);

    $display("[TB] sign-sensitive operands");
    apply_stimulus(16'hFFFF, 16'h0001, 0, 0, 0);
    check_output("sign", 0);
    apply_stimulus(16'h7FFF, 16'h8000, 1, 0, 0);
    check_output("sign_edge", 0);

    $display("[TB] result ready held high during accumulation");
    res_ready = 1'b1;
    send_beat(4'h3, 4'h3);
    check("rr_ignored_busy", busy, 1'b1);
    res_ready = 1'b0;
    send_beat(4'h4, 4'h4);
    send_beat(4'h0, 4'h0);
    send_beat(4'h1, 4'h2);
    sb.push_back(model(16'h3401, 16'h3402));
    check_output("rr_accum", 0);

    $display("[TB] random operands");
    for (int k = 0; k < 6; k++) begin
      ra = 16'($urandom);
      rb = (k % 2 == 0) ? ra ^ 16'(1 << $urandom_range(0, 15)) : 16'($urandom);
      apply_stimulus(ra, rb, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      check_output("random", $urandom_range(0, 2));
    end

    check("sb_drained", sb.size(), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
